aes_inv_round_ctrl: RTL and testbench
=====================================

Name: aes_inv_round_ctrl

Overview:
Iterative AES decryption scheduler. Accepts one 128-bit ciphertext block per valid/ready handshake and sequences NR+1 passes through an external inverse-round datapath (InvShiftRows/InvSubBytes/AddRoundKey/InvMixColumns). Each pass uses round key NR down to 0, fetched from an asynchronous-read key store. Sits between the block interface and the inverse-round unit; owns the state register and the round counter.

Parameters:
DATA_W, 128, block/key width in bits
NR, 10, number of cipher rounds (10/12/14 for AES-128/192/256)
TIMEOUT, 64, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  ciphertext valid
in_ready  out  1  controller can accept a block
in_data  in  DATA_W  ciphertext
key_idx  out  $clog2(NR+1)  round-key index to key store
round_key  in  DATA_W  key-store read data for key_idx (same cycle)
dp_valid  out  1  issue strobe to inverse-round datapath
dp_mode  out  2  0=ARK_ONLY, 1=FULL (with InvMixColumns), 2=FINAL (no InvMixColumns)
dp_data  out  DATA_W  state sent to datapath
dp_key  out  DATA_W  round key sent to datapath
dp_valid_in  in  1  datapath result valid
dp_data_in  in  DATA_W  datapath result
out_valid  out  1  plaintext valid
out_ready  in  1  downstream accepts plaintext
out_data  out  DATA_W  plaintext
busy  out  1  block in flight (state != IDLE)

Behaviour:
- Clock clk; reset asynchronous, active-high. While reset is high: state=IDLE, round=0, state_reg=0, dp_valid=0, out_valid=0, out_data=0, busy=0, dp_data=0, dp_key=0, dp_mode=0. in_ready=1, but no handshake is honoured.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: in_ready=1. On in_valid, capture state_reg<=in_data and round<=NR; go to ISSUE.
- ISSUE: dp_valid=1 for exactly one cycle; dp_data=state_reg; dp_key=round_key; key_idx=round.
  - dp_mode = ARK_ONLY if round==NR, FINAL if round==0, else FULL.
  - Next state: WAIT.
- WAIT: dp_valid=0. On dp_valid_in:
  - state_reg<=dp_data_in.
  - If round==0: go to DONE. Else: round<=round-1 and go to ISSUE.
- DONE: out_valid=1; out_data=state_reg. Hold until out_ready, then go to IDLE (in_ready rises the next cycle; no same-cycle turnaround).
- key_idx is always driven from the round register (0 outside ISSUE/WAIT is acceptable).
- Datapath latency L>=1, measured from the dp_valid cycle to the dp_valid_in cycle.
  - Latency from the in_valid&&in_ready edge to out_valid = (NR+1)*(L+1)+1 cycles.
  - NR=10, L=1 gives 23 cycles.
- dp_valid_in in any state other than WAIT is ignored.
- out_valid stays high and out_data stays stable while out_ready is low (no drop or change under backpressure).
- in_valid outside IDLE is ignored (in_ready=0). There is no input buffering.
- Reset mid-operation discards the block immediately; there is no partial output.
- round width is $clog2(NR+1). Decrement only when round>0, so the counter never wraps.

Optional Feature:
AES_INV_CTRL_TIMEOUT_EN:
- Defined: adds a watchdog counter, cleared on entry to WAIT and incremented each WAIT cycle. If it reaches TIMEOUT without dp_valid_in:
  - FSM returns to IDLE and state_reg clears.
  - Output port err (1 bit) pulses for one cycle; err resets to 0.
- Undefined: no counter and no err port; WAIT waits indefinitely.

Decomposition:
- Shared package aes_pkg holds:
  - dp_mode encodings: ARK_ONLY, FULL, FINAL.
  - FSM state typedef.
  - NR constants for the 128/192/256 variants.
  - Default DATA_W.
- One natural sub-module, aes_round_counter: load NR, decrement, is_first/is_last flags.
- The FSM stays in the top module.

Test Plan:
1. FIPS-197 C.1: key store loaded with the expansion of 000102…0f; in_data=69c4e0d86a7b0430d8cdb78070b4c55a; behavioural datapath model with L=1 -> out_data=00112233445566778899aabbccddeeff, out_valid exactly 23 cycles after accept.
2. Key and mode sequencing: log dp_valid cycles -> key_idx sequence 10,9,…,0; dp_mode ARK_ONLY once, FULL 9 times, FINAL once.
3. Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid held, out_data stable, in_ready=0, a second in_valid ignored; accepted after out_ready.
4. Stray and late handshakes:
   - dp_valid_in pulsed during IDLE and ISSUE -> state_reg unchanged.
   - Datapath with L=4 -> out_valid at 56 cycles.
5. Reset mid-operation: reset asserted in WAIT of round 5 -> outputs zero asynchronously; after release, in_ready=1 and the next block decrypts correctly.
6. With AES_INV_CTRL_TIMEOUT_EN, TIMEOUT=8, datapath silent -> err pulses 8 cycles after entering WAIT, FSM returns to IDLE, out_valid never asserted.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES decryption controller definitions: datapath mode encodings,
// controller FSM states, round counts per key size and the default block width.
package aes_pkg;

  localparam int AES_DATA_W = 128;

  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

  typedef enum logic [1:0] {
    ARK_ONLY = 2'd0,
    FULL     = 2'd1,
    FINAL    = 2'd2
  } dp_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/aes_round_counter.sv
// Round-key index counter for the inverse cipher: loads NR, counts down and
// saturates at zero; flags the first (ARK-only) and last (final) rounds.
module aes_round_counter
  import aes_pkg::*;
#(
  parameter int NR = NR_128
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic                    dec,
  output logic [$clog2(NR+1)-1:0] round,
  output logic                    is_first,
  output logic                    is_last
);

  localparam int RW = $clog2(NR+1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      round <= '0;
    end else if (load) begin
      round <= RW'(NR);
    end else if (dec && (round != '0)) begin
      round <= round - 1'b1;
    end
  end

  assign is_first = (round == RW'(NR));
  assign is_last  = (round == '0);

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES decryption scheduler driving an external inverse-round datapath.
// Optional watchdog on the datapath response: define AES_INV_CTRL_TIMEOUT_EN.
module aes_inv_round_ctrl
  import aes_pkg::*;
#(
  parameter int DATA_W  = AES_DATA_W,
  parameter int NR      = NR_128,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  output logic [$clog2(NR+1)-1:0] key_idx,
  input  logic [DATA_W-1:0]       round_key,
  output logic                    dp_valid,
  output logic [1:0]              dp_mode,
  output logic [DATA_W-1:0]       dp_data,
  output logic [DATA_W-1:0]       dp_key,
  input  logic                    dp_valid_in,
  input  logic [DATA_W-1:0]       dp_data_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic                    busy
`ifdef AES_INV_CTRL_TIMEOUT_EN
  ,
  output logic                    err
`endif
);

  localparam int RW = $clog2(NR+1);

  ctrl_state_e       state, state_nxt;
  logic [RW-1:0]     round;
  logic              is_first, is_last;
  logic              load, dec, cap_in, cap_dp, abort;
  logic [DATA_W-1:0] state_reg;
  dp_mode_e          mode_sel;

  aes_round_counter #(.NR(NR)) u_round_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .dec      (dec),
    .round    (round),
    .is_first (is_first),
    .is_last  (is_last)
  );

`ifdef AES_INV_CTRL_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT+1);
  logic [WDW-1:0] wd_cnt;

  // Fires in the TIMEOUT-th consecutive WAIT cycle without a datapath response.
  assign abort = (state == WAIT) && !dp_valid_in && (wd_cnt == WDW'(TIMEOUT-1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      err <= abort;
      if (state != WAIT) begin
        wd_cnt <= '0;
      end else if (!abort) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    dec       = 1'b0;
    cap_in    = 1'b0;
    cap_dp    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = ISSUE;
          load      = 1'b1;
          cap_in    = 1'b1;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (dp_valid_in) begin
          cap_dp = 1'b1;
          if (is_last) begin
            state_nxt = DONE;
          end else begin
            dec       = 1'b1;
            state_nxt = ISSUE;
          end
        end else if (abort) begin
          state_nxt = IDLE;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= '0;
    end else if (cap_in) begin
      state_reg <= in_data;
    end else if (cap_dp) begin
      state_reg <= dp_data_in;
    end else if (abort) begin
      state_reg <= '0;
    end
  end

  always_comb begin
    mode_sel = FULL;
    if (is_first) begin
      mode_sel = ARK_ONLY;
    end else if (is_last) begin
      mode_sel = FINAL;
    end
  end

  // Datapath-facing buses are zeroed outside ISSUE so nothing leaks while idle or in reset.
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign key_idx   = round;
  assign dp_valid  = (state == ISSUE);
  assign dp_mode   = (state == ISSUE) ? mode_sel : ARK_ONLY;
  assign dp_data   = (state == ISSUE) ? state_reg : '0;
  assign dp_key    = (state == ISSUE) ? round_key : '0;
  assign out_valid = (state == DONE);
  assign out_data  = (state == DONE) ? state_reg : '0;

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl: AES-128 key store, behavioural inverse-round
// datapath with programmable latency, and a full AES decryption reference.
module tb_aes_inv_round_ctrl;

  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   key_idx;
  logic [127:0] round_key;
  logic         dp_valid;
  logic [1:0]   dp_mode;
  logic [127:0] dp_data;
  logic [127:0] dp_key;
  logic         dp_valid_in = 1'b0;
  logic [127:0] dp_data_in  = '0;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
`ifdef AES_INV_CTRL_TIMEOUT_EN
  logic         err;
`endif

  aes_inv_round_ctrl #(.DATA_W(128), .NR(NR), .TIMEOUT(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .key_idx     (key_idx),
    .round_key   (round_key),
    .dp_valid    (dp_valid),
    .dp_mode     (dp_mode),
    .dp_data     (dp_data),
    .dp_key      (dp_key),
    .dp_valid_in (dp_valid_in),
    .dp_data_in  (dp_data_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy)
`ifdef AES_INV_CTRL_TIMEOUT_EN
    ,
    .err         (err)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- AES reference primitives ----------------
  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] rk    [NR+1];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
  endtask

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // mode 0: AddRoundKey only; 1: InvShiftRows, InvSubBytes, ARK, InvMixColumns; else: without InvMixColumns
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k, input int mode);
    logic [127:0] t;
    logic [7:0]   a [4];
    logic [7:0]   cf [4];
    logic [7:0]   b;
    cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
    if (mode == 0) return s ^ k;
    t = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[127-8*(r+4*c) -: 8] = isbox[gb(s, r + 4*((c - r + 4) % 4))];
    t = t ^ k;
    if (mode == 1) begin
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) a[r] = gb(t, r + 4*c);
        for (int r = 0; r < 4; r++) begin
          b = 8'h00;
          for (int j = 0; j < 4; j++) b = b ^ gm(a[j], cf[(j - r + 4) % 4]);
          t[127-8*(r+4*c) -: 8] = b;
        end
      end
    end
    return t;
  endfunction

  function automatic logic [127:0] ref_dec(input logic [127:0] ct);
    logic [127:0] s;
    s = ct ^ rk[NR];
    for (int r = NR-1; r >= 1; r--) s = inv_round(s, rk[r], 1);
    return inv_round(s, rk[0], 2);
  endfunction

  assign round_key = (key_idx <= 4'(NR)) ? rk[key_idx] : '0;

  // ---------------- behavioural datapath + issue monitor ----------------
  int           lat_l   = 1;
  int           rem     = 0;
  int           iss_n   = 0;
  int           n_ark   = 0;
  int           n_full  = 0;
  int           n_fin   = 0;
  bit           stray_en = 1'b0;
  bit           silent   = 1'b0;
  logic [127:0] pend;
  logic [127:0] exp_st;

  always @(negedge clk) begin
    if (reset) begin
      rem         = 0;
      dp_valid_in = 1'b0;
    end else begin
      dp_valid_in = 1'b0;
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          dp_valid_in = 1'b1;
          dp_data_in  = pend;
          exp_st      = pend;
        end
      end
      // Stray responses only outside WAIT, where the controller must ignore them.
      if (!dp_valid_in && stray_en && !(busy && !dp_valid && !out_valid) &&
          $urandom_range(0, 1) == 1) begin
        dp_valid_in = 1'b1;
        dp_data_in  = {$urandom, $urandom, $urandom, $urandom};
      end
      if (dp_valid && !silent) begin
        if (iss_n <= NR) begin
          chk("key_idx", key_idx, 128'(NR - iss_n));
          chk("dp_mode", dp_mode, (iss_n == 0) ? 128'd0 : (iss_n == NR) ? 128'd2 : 128'd1);
          chk("dp_key", dp_key, rk[NR - iss_n]);
          chk("dp_data", dp_data, exp_st);
        end else begin
          chk("extra_issue", 128'(iss_n), 128'(NR));
        end
        case (dp_mode)
          2'd0:    n_ark++;
          2'd1:    n_full++;
          default: n_fin++;
        endcase
        iss_n++;
        pend = inv_round(dp_data, dp_key, int'(dp_mode));
        rem  = lat_l;
      end
    end
  end

  // ---------------- block driver ----------------
  task automatic run_block(input logic [127:0] ct, input logic [127:0] exp_pt,
                           input int l, input int bp, input int abort_rnd);
    int           lat;
    int           guard;
    logic [127:0] held;
    lat_l  = l;
    iss_n  = 0;
    n_ark  = 0;
    n_full = 0;
    n_fin  = 0;
    exp_st = ct;
    guard  = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_data  = ct;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    lat      = 1;
    while (!out_valid && lat < 400) begin
      if (abort_rnd >= 0 && busy && !dp_valid && !out_valid && key_idx == 4'(abort_rnd)) begin
        #2 reset = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_dp_valid", dp_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_dp_data", dp_data, 0);
        chk("rst_dp_key", dp_key, 0);
        chk("rst_dp_mode", dp_mode, 0);
        chk("rst_key_idx", key_idx, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        return;
      end
      @(negedge clk);
      lat++;
    end
    chk("latency", 128'(lat), 128'((NR + 1) * (l + 1) + 1));
    chk("plaintext", out_data, exp_pt);
    held = out_data;
    for (int i = 0; i < bp; i++) begin
      if (i == 1) begin
        in_valid = 1'b1;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, held);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("consumed", out_valid, 0);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_busy", busy, 0);
    chk("issue_count", 128'(iss_n), 128'(NR + 1));
    chk("n_ark_only", 128'(n_ark), 1);
    chk("n_full", 128'(n_full), 128'(NR - 1));
    chk("n_final", 128'(n_fin), 1);
  endtask

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

  initial begin
    logic [127:0] key, ct;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    build_sbox();
    load_key(FIPS_KEY);
    chk("ref_model_fips", ref_dec(FIPS_CT), FIPS_PT);

    // Reset state, with a handshake attempt that must not be honoured
    repeat (2) @(negedge clk);
    in_valid = 1'b1;
    in_data  = FIPS_CT;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_dp_valid", dp_valid, 0);
    chk("reset_key_idx", key_idx, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_dp_data", dp_data, 0);
    in_valid = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    chk("no_handshake_in_reset", busy, 0);

    // FIPS-197 C.1, L=1, with backpressure
    run_block(FIPS_CT, FIPS_PT, 1, 5, -1);
    // Long datapath latency with stray responses outside WAIT
    stray_en = 1'b1;
    run_block(FIPS_CT, FIPS_PT, 4, 0, -1);
    stray_en = 1'b0;
    // Reset in WAIT of round 5, then a clean block
    run_block(FIPS_CT, FIPS_PT, 3, 0, 5);
    run_block(FIPS_CT, FIPS_PT, 2, 1, -1);

    for (int n = 0; n < 25; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      ct  = {$urandom, $urandom, $urandom, $urandom};
      load_key(key);
      stray_en = ($urandom_range(0, 1) == 1);
      run_block(ct, ref_dec(ct), int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), -1);
    end
    stray_en = 1'b0;

`ifdef AES_INV_CTRL_TIMEOUT_EN
    begin
      int w;
      bit seen_ov;
      silent   = 1'b1;
      seen_ov  = 1'b0;
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      in_valid = 1'b0;
      chk("to_issue", dp_valid, 1);
      @(negedge clk);
      w = 0;
      while (!err && w < 40) begin
        if (out_valid) seen_ov = 1'b1;
        @(negedge clk);
        w++;
      end
      chk("to_err_delay", 128'(w), 8);
      chk("to_idle", busy, 0);
      chk("to_no_out_valid", 128'(seen_ov), 0);
      @(negedge clk);
      chk("to_err_pulse", err, 0);
      silent = 1'b0;
      load_key(FIPS_KEY);
      run_block(FIPS_CT, FIPS_PT, 1, 0, -1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule
